// File: rtl/sobel_kernel.sv
// Three-stage Sobel gradient-magnitude kernel fed one vertical pixel column per cycle.
// Define SOBEL_THRESHOLD_EN to turn the magnitude into a binary edge map against thr_i.
module sobel_kernel #(
  parameter int COLORDEPTH = 8,
  parameter int BUF_DEPTH  = 3
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [BUF_DEPTH-1:0][COLORDEPTH-1:0]  col_i,
  input  logic                                  dv_i,
  input  logic                                  hs_i,
  input  logic                                  vs_i,
  input  logic [COLORDEPTH-1:0]                 thr_i,
  output logic [COLORDEPTH-1:0]                 data_o,
  output logic                                  dv_o,
  output logic                                  hs_o,
  output logic                                  vs_o
);

  localparam int GW = COLORDEPTH + 4;

  // Handshake: dv_i marks a valid column on the cycle it is high; there is no
  // ready, every column is accepted, and dv_o marks data_o valid 3 stages later.

  // r_win[row][col]: row 0 is the newest line, col 0 the newest column.
  logic [COLORDEPTH-1:0]   r_win [3][3];
  logic [1:0]              r_colcnt;
  logic                    r_brd1, r_dv1, r_hs1, r_vs1;
  logic signed [GW-1:0]    r_gx, r_gy;
  logic                    r_brd2, r_dv2, r_hs2, r_vs2;

  logic                    w_clr;
  logic                    w_brd;
  logic signed [GW-1:0]    w_gx, w_gy;
  logic [GW-1:0]           w_ax, w_ay, w_mag;
  logic [COLORDEPTH-1:0]   w_pix;

  function automatic logic signed [GW-1:0] ext(input logic [COLORDEPTH-1:0] p);
    return $signed({{(GW-COLORDEPTH){1'b0}}, p});
  endfunction

  // A pixel needs three columns of its own line; a sync pulse restarts the count.
  assign w_clr = hs_i | vs_i;
  assign w_brd = w_clr | (r_colcnt != 2'd2);

  // Stage 1: window shift, column counter, border flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          r_win[r][c] <= '0;
        end
      end
      r_colcnt <= 2'd0;
      r_brd1   <= 1'b0;
      r_dv1    <= 1'b0;
      r_hs1    <= 1'b0;
      r_vs1    <= 1'b0;
    end else begin
      if (dv_i) begin
        for (int r = 0; r < 3; r++) begin
          r_win[r][2] <= r_win[r][1];
          r_win[r][1] <= r_win[r][0];
          r_win[r][0] <= col_i[r];
        end
      end
      if (w_clr) begin
        r_colcnt <= 2'd0;
      end else if (dv_i && (r_colcnt != 2'd2)) begin
        r_colcnt <= r_colcnt + 2'd1;
      end
      r_brd1 <= w_brd;
      r_dv1  <= dv_i;
      r_hs1  <= hs_i;
      r_vs1  <= vs_i;
    end
  end

  assign w_gx = (ext(r_win[0][0]) + (ext(r_win[1][0]) <<< 1) + ext(r_win[2][0]))
              - (ext(r_win[0][2]) + (ext(r_win[1][2]) <<< 1) + ext(r_win[2][2]));
  assign w_gy = (ext(r_win[0][2]) + (ext(r_win[0][1]) <<< 1) + ext(r_win[0][0]))
              - (ext(r_win[2][2]) + (ext(r_win[2][1]) <<< 1) + ext(r_win[2][0]));

  // Stage 2: signed gradients.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_gx   <= '0;
      r_gy   <= '0;
      r_brd2 <= 1'b0;
      r_dv2  <= 1'b0;
      r_hs2  <= 1'b0;
      r_vs2  <= 1'b0;
    end else begin
      r_gx   <= w_gx;
      r_gy   <= w_gy;
      r_brd2 <= r_brd1;
      r_dv2  <= r_dv1;
      r_hs2  <= r_hs1;
      r_vs2  <= r_vs1;
    end
  end

  // |G| never exceeds 4*(2^COLORDEPTH-1) per axis, so the sum fits GW bits unsigned.
  assign w_ax  = r_gx[GW-1] ? $unsigned(-r_gx) : $unsigned(r_gx);
  assign w_ay  = r_gy[GW-1] ? $unsigned(-r_gy) : $unsigned(r_gy);
  assign w_mag = w_ax + w_ay;

`ifdef SOBEL_THRESHOLD_EN
  assign w_pix = (w_mag >= {{(GW-COLORDEPTH){1'b0}}, thr_i}) ? '1 : '0;
`else
  logic w_unused_thr;
  assign w_unused_thr = ^thr_i;
  assign w_pix = (|w_mag[GW-1:COLORDEPTH]) ? '1 : w_mag[COLORDEPTH-1:0];
`endif

  // Stage 3: output register holds between valid pixels.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_o <= '0;
      dv_o   <= 1'b0;
      hs_o   <= 1'b0;
      vs_o   <= 1'b0;
    end else begin
      if (r_dv2) begin
        data_o <= r_brd2 ? '0 : w_pix;
      end
      dv_o <= r_dv2;
      hs_o <= r_hs2;
      vs_o <= r_vs2;
    end
  end

endmodule
